// File: rtl/spi_master_seq.sv
// Push-button driven SPI_MASTER traffic sequencer: bursts of patterned frames with
// DIN_LAST framing, inter-burst gap, slave-address rotation and loopback checking.
module spi_master_seq #(
  parameter int DATA_W          = 8,
  parameter int BURST_LEN       = 4,
  parameter int GAP_CYCLES      = 10,
  parameter int SLAVE_COUNT     = 1,
  parameter int ADDR_W          = 1,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              continuous,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_din_last,
  output logic              m_din_vld,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_dout_vld,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [15:0]       err_count,
  output logic [DATA_W-1:0] last_rx
);

  localparam int K_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int G_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DEPTH = 4;

  localparam logic [K_W-1:0]    K_LAST  = K_W'(BURST_LEN - 1);
  localparam logic [G_W-1:0]    G_LAST  = G_W'(GAP_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(SLAVE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

  state_t            state;
  logic [K_W-1:0]    k;
  logic [G_W-1:0]    gap_cnt;
  logic [1:0]        run_mode;
  logic              stop_pending;

  logic              sync_a, sync_b, btn, btn_d;
  logic [DB_W-1:0]   db_cnt;
  logic              press;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_cnt, fifo_cnt_next;
  logic              accept, pop, can_present, mismatch;

  function automatic logic [DATA_W-1:0] start_value(input logic [1:0] md,
                                                    input logic [DATA_W-1:0] pat);
    logic [DATA_W-1:0] v;
    case (md)
      2'b10:   v = (pat == '0) ? DATA_W'(1) : pat;
      2'b11:   v = DATA_W'(1);
      default: v = pat;
    endcase
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [1:0] md,
                                                input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    case (md)
      2'b00:   v = d + DATA_W'(1);
      2'b01:   v = d;
      2'b10:   v = {d[DATA_W-2:0], d[DATA_W-1] ^ d[DATA_W-2]};
      default: v = {d[DATA_W-2:0], d[DATA_W-1]};
    endcase
    return v;
  endfunction

  // The debounced level only follows the synchronised button after it has held
  // its new level for DEBOUNCE_CYCLES samples; a press is its falling edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      btn    <= 1'b1;
      btn_d  <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync_a <= start_n;
      sync_b <= sync_a;
      btn_d  <= btn;
      if (sync_b != btn) begin
        if (db_cnt == DB_LAST) begin
          btn    <= sync_b;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_d & ~btn;

  always_comb begin
    accept        = m_din_vld & m_ready;
    pop           = m_dout_vld & (fifo_cnt != 3'd0);
    fifo_cnt_next = fifo_cnt + {2'b00, accept} - {2'b00, pop};
    can_present   = (fifo_cnt_next != 3'(DEPTH));
    mismatch      = m_dout_vld & ((fifo_cnt == 3'd0) | (m_dout != fifo_mem[rd_ptr]));
  end

  always_ff @(posedge clock) begin
    if (accept) fifo_mem[wr_ptr] <= m_din;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      frame_count <= '0;
      err_count   <= '0;
      last_rx     <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_next;
      if (accept) begin
        wr_ptr      <= wr_ptr + 2'd1;
        frame_count <= frame_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (m_dout_vld) last_rx <= m_dout;
      if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  // Outputs are set for the state being entered so they stay registered; m_din
  // doubles as the data register and only moves on acceptance.
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      m_din_vld    <= 1'b0;
      m_din_last   <= 1'b0;
      m_din        <= '0;
      m_addr       <= '0;
      k            <= '0;
      gap_cnt      <= '0;
      run_mode     <= 2'b00;
      stop_pending <= 1'b0;
    end else begin
      if (press && state != IDLE) stop_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (press) begin
            state      <= SEND;
            busy       <= 1'b1;
            run_mode   <= mode;
            m_din      <= start_value(mode, pattern);
            k          <= '0;
            m_din_vld  <= can_present;
            m_din_last <= (K_LAST == '0);
          end
        end
        SEND: begin
          if (accept) begin
            m_din <= advance(run_mode, m_din);
            if (k == K_LAST) begin
              state      <= DRAIN;
              m_din_vld  <= 1'b0;
              m_din_last <= 1'b0;
            end else begin
              k          <= k + K_W'(1);
              m_din_vld  <= can_present;
              m_din_last <= ((k + K_W'(1)) == K_LAST);
            end
          end else begin
            m_din_vld <= can_present;
          end
        end
        DRAIN: begin
          if (fifo_cnt == 3'd0) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == G_LAST) begin
            m_addr <= (m_addr == A_LAST) ? '0 : m_addr + ADDR_W'(1);
            if (continuous && !stop_pending && !press) begin
              state      <= SEND;
              k          <= '0;
              m_din_vld  <= can_present;
              m_din_last <= (K_LAST == '0);
            end else begin
              state        <= IDLE;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + G_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: MOSI->MISO loopback responder, frame monitor
// and hand-computed expected bursts.
module tb_spi_master_seq;

  logic        clock = 1'b0;
  logic        rst, start_n, continuous;
  logic [1:0]  mode;
  logic [7:0]  pattern;
  logic [1:0]  m_addr;
  logic [7:0]  m_din;
  logic        m_din_last, m_din_vld;
  logic        m_ready;
  logic [7:0]  m_dout;
  logic        m_dout_vld;
  logic        busy;
  logic [15:0] frame_count, err_count;
  logic [7:0]  last_rx;

  logic        readyLevel, toggleEn, manVld;
  logic [7:0]  manData;
  int          corruptAt;

  logic        respHold = 1'b0;
  logic [7:0]  respHoldData = 8'h00;
  logic        respVld = 1'b0;
  logic [7:0]  respData = 8'h00;
  int          respTotal = 0;

  logic        stallSeen = 1'b0, stallRst = 1'b0, stallLast = 1'b0;
  logic [7:0]  stallDin = 8'h00;

  logic [7:0]  accQ[$];
  logic        lastQ[$];
  logic [1:0]  addrQ[$];

  int          errorCount = 0;
  int          checkCount = 0;

  spi_master_seq #(
    .DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(10), .SLAVE_COUNT(3), .ADDR_W(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .rst(rst), .start_n(start_n), .mode(mode), .pattern(pattern),
    .continuous(continuous), .m_addr(m_addr), .m_din(m_din), .m_din_last(m_din_last),
    .m_din_vld(m_din_vld), .m_ready(m_ready), .m_dout(m_dout), .m_dout_vld(m_dout_vld),
    .busy(busy), .frame_count(frame_count), .err_count(err_count), .last_rx(last_rx)
  );

  always #5 clock = ~clock;

  assign m_dout_vld = respVld | manVld;
  assign m_dout     = manVld ? manData : respData;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pressButton(input int len);
    start_n = 1'b0;
    tick(len);
    start_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] md, input logic [7:0] pat,
                               input logic cont, input int len);
    mode       = md;
    pattern    = pat;
    continuous = cont;
    pressButton(len);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin tick(1); n++; end
    while (busy !== 1'b0 && n < budget) begin tick(1); n++; end
    checkOutput("idle_timeout", 32'(n >= budget), 0);
  endtask

  task automatic waitFrames(input int count, input int budget);
    int n = 0;
    while (accQ.size() < count && n < budget) begin tick(1); n++; end
    checkOutput("frame_timeout", 32'(n >= budget), 0);
  endtask

  task automatic checkBurst(input string name, input int base, input logic [31:0] frames,
                            input int addr);
    checkOutput({name, "_len"}, 32'(accQ.size() - base), 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < accQ.size()) begin
        checkOutput({name, "_data"}, 32'(accQ[base+i]), 32'(frames[31-8*i -: 8]));
        checkOutput({name, "_last"}, 32'(lastQ[base+i]), (i == 3) ? 1 : 0);
        checkOutput({name, "_addr"}, 32'(addrQ[base+i]), addr);
      end
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_vld"}, 32'(m_din_vld), 0);
    checkOutput({name, "_last"}, 32'(m_din_last), 0);
    checkOutput({name, "_din"}, 32'(m_din), 0);
    checkOutput({name, "_addr"}, 32'(m_addr), 0);
    checkOutput({name, "_busy"}, 32'(busy), 0);
    checkOutput({name, "_frames"}, 32'(frame_count), 0);
    checkOutput({name, "_errs"}, 32'(err_count), 0);
    checkOutput({name, "_rx"}, 32'(last_rx), 0);
  endtask

  // Record every frame the DUT will accept at the coming edge and check that a
  // stalled frame is held unchanged.
  always @(negedge clock) begin
    if (rst === 1'b0 && m_din_vld === 1'b1 && m_ready === 1'b1) begin
      accQ.push_back(m_din);
      lastQ.push_back(m_din_last);
      addrQ.push_back(m_addr);
      respHold     = 1'b1;
      respHoldData = m_din;
    end else begin
      respHold = 1'b0;
    end
    if (stallSeen && !stallRst) begin
      checkOutput("hold_vld", 32'(m_din_vld), 1);
      checkOutput("hold_din", 32'(m_din), 32'(stallDin));
      checkOutput("hold_last", 32'(m_din_last), 32'(stallLast));
    end
    stallSeen = (m_din_vld === 1'b1) && (m_ready === 1'b0);
    stallRst  = rst;
    stallDin  = m_din;
    stallLast = m_din_last;
  end

  always @(posedge clock) begin
    #1;
    if (respHold) begin
      respTotal++;
      respData = (respTotal == corruptAt) ? (respHoldData ^ 8'hA5) : respHoldData;
      respVld  = 1'b1;
    end else begin
      respVld = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    m_ready = toggleEn ? ~m_ready : readyLevel;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; start_n = 1'b1; mode = 2'b00; pattern = 8'h00; continuous = 1'b0;
    readyLevel = 1'b1; toggleEn = 1'b0; manVld = 1'b0; manData = 8'h00; corruptAt = 0;
    tick(3);
    checkResetValues("reset");
    rst = 1'b0;
    tick(5);

    base = accQ.size();
    applyStimulus(2'b00, 8'hFE, 1'b0, 6);
    waitIdle(200);
    checkBurst("incr", base, 32'hFEFF0001, 0);
    checkOutput("incr_frames", 32'(frame_count), 4);
    checkOutput("incr_errs", 32'(err_count), 0);
    checkOutput("incr_busy", 32'(busy), 0);
    tick(10);

    pressButton(3);
    tick(20);
    checkOutput("glitch_frames", 32'(frame_count), 4);
    checkOutput("glitch_busy", 32'(busy), 0);
    base = accQ.size();
    applyStimulus(2'b00, 8'h20, 1'b0, 10);
    waitIdle(200);
    checkBurst("long_press", base, 32'h20212223, 1);
    checkOutput("long_press_frames", 32'(frame_count), 8);
    tick(10);

    base = accQ.size();
    applyStimulus(2'b10, 8'h40, 1'b0, 6);
    waitIdle(200);
    checkBurst("lfsr", base, 32'h40810306, 2);
    tick(10);
    base = accQ.size();
    applyStimulus(2'b10, 8'h00, 1'b0, 6);
    waitIdle(200);
    checkBurst("lfsr_zero", base, 32'h01020408, 0);
    tick(10);
    base = accQ.size();
    applyStimulus(2'b11, 8'h5A, 1'b0, 6);
    waitIdle(200);
    checkBurst("walk", base, 32'h01020408, 1);
    tick(10);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    base = accQ.size();
    applyStimulus(2'b00, 8'h10, 1'b1, 6);
    waitFrames(base + 13, 300);
    pressButton(6);
    waitIdle(300);
    continuous = 1'b0;
    checkOutput("cont_len", 32'(accQ.size() - base), 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < accQ.size()) begin
        checkOutput("cont_data", 32'(accQ[base+i]), 'h10 + i);
        checkOutput("cont_addr", 32'(addrQ[base+i]), (i / 4) % 3);
        checkOutput("cont_last", 32'(lastQ[base+i]), ((i % 4) == 3) ? 1 : 0);
      end
    end
    checkOutput("cont_frames", 32'(frame_count), 16);
    checkOutput("cont_errs", 32'(err_count), 0);
    tick(10);

    base = accQ.size();
    corruptAt = respTotal + 2;
    toggleEn = 1'b1;
    applyStimulus(2'b00, 8'h30, 1'b0, 6);
    begin
      int n = 0;
      while (err_count == 16'd0 && n < 100) begin tick(1); n++; end
    end
    checkOutput("corrupt_errs", 32'(err_count), 1);
    checkOutput("corrupt_rx", 32'(last_rx), 'h94);
    waitIdle(300);
    toggleEn = 1'b0;
    checkBurst("ready_toggle", base, 32'h30313233, 1);
    checkOutput("toggle_frames", 32'(frame_count), 20);
    checkOutput("toggle_errs", 32'(err_count), 1);
    checkOutput("toggle_rx", 32'(last_rx), 'h33);
    tick(5);
    manData = 8'h77;
    manVld = 1'b1;
    tick(1);
    manVld = 1'b0;
    tick(1);
    checkOutput("idle_rx_errs", 32'(err_count), 2);
    checkOutput("idle_rx_data", 32'(last_rx), 'h77);
    tick(10);

    base = accQ.size();
    applyStimulus(2'b00, 8'h50, 1'b0, 6);
    waitFrames(base + 2, 50);
    rst = 1'b1;
    tick(1);
    checkResetValues("mid_reset");
    rst = 1'b0;
    tick(20);
    checkOutput("post_reset_len", 32'(accQ.size() - base), 2);
    checkOutput("post_reset_frames", 32'(frame_count), 0);
    checkOutput("post_reset_errs", 32'(err_count), 0);
    base = accQ.size();
    applyStimulus(2'b00, 8'h50, 1'b0, 6);
    waitIdle(200);
    checkBurst("after_reset", base, 32'h50515253, 0);
    checkOutput("after_reset_frames", 32'(frame_count), 4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_master_seq.md
# spi_master_seq

Parametrised SPI-master traffic sequencer that replaces the fixed "one incrementing byte per counter wrap" test logic in the FPGA top level. On a debounced push-button press it drives bursts of frames into the SPI_MASTER user interface: selectable data pattern, configurable burst length with DIN_LAST framing, an inter-burst gap, and slave-address rotation. It also checks returned frames against transmitted frames for MOSI→MISO loopback testing and exposes status counters for the LEDs and debug.

## Interface
- DATA_W, 8, frame width; must match SPI_MASTER data width; ≥ 2
- BURST_LEN, 4, frames per CS assertion; ≥ 1
- GAP_CYCLES, 10, idle clock cycles between bursts; ≥ 1
- SLAVE_COUNT, 1, number of SPI slaves addressed in rotation
- ADDR_W, 1, address width; ≥ clog2(SLAVE_COUNT), minimum 1
- DEBOUNCE_CYCLES, 240000, stable-low cycles needed to register a press (10 ms at 24 MHz)

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_n  in  1  push button, active-low, asynchronous; double-flop synchronised internally
- mode  in  2  00 increment, 01 constant, 10 LFSR, 11 walking-one; sampled at run start
- pattern  in  DATA_W  seed/constant value; sampled at run start
- continuous  in  1  1: repeat bursts until the next press; 0: one burst per press
- m_addr  out  ADDR_W  to SPI_MASTER ADDR
- m_din  out  DATA_W  to SPI_MASTER DIN
- m_din_last  out  1  to SPI_MASTER DIN_LAST
- m_din_vld  out  1  to SPI_MASTER DIN_VLD
- m_ready  in  1  from SPI_MASTER READY
- m_dout  in  DATA_W  from SPI_MASTER DOUT
- m_dout_vld  in  1  from SPI_MASTER DOUT_VLD
- busy  out  1  high in any state other than IDLE
- frame_count  out  16  accepted tx frames; wraps modulo 2^16
- err_count  out  16  rx mismatches; saturates at 0xFFFF
- last_rx  out  DATA_W  most recent m_dout

## Operation
- Press event: falling edge of the debounced button. The debounced signal changes only after the synchronised input has held its new level for DEBOUNCE_CYCLES consecutive cycles.
- FSM states: IDLE, SEND, DRAIN, GAP.
  - IDLE → SEND on a press. The data register loads its run-start value and frame index k = 0.
  - SEND: m_din_vld = 1. A frame is accepted on any cycle where m_din_vld and m_ready are both high. On acceptance: push m_din into the expect FIFO, increment frame_count, advance the data register, and increment k. Acceptance at k = BURST_LEN-1 moves to DRAIN.
  - DRAIN: wait until the expect FIFO is empty, then go to GAP.
  - GAP: count GAP_CYCLES cycles, then advance m_addr (wraps at SLAVE_COUNT-1 to 0). Next state is SEND (k = 0, data register NOT reloaded) if continuous is set and no stop is pending; otherwise IDLE.
- Stop: a press while busy sets stop_pending. The current burst always completes, including DRAIN and GAP. stop_pending clears on entry to IDLE.
- m_din_last = 1 exactly when k = BURST_LEN-1 while in SEND.
- Data register run-start value and advance rule:
  - increment: starts at pattern; advances +1 modulo 2^DATA_W
  - constant: starts at pattern; never changes
  - LFSR: starts at pattern, with 0 replaced by 1; advances to {d[DATA_W-2:0], d[DATA_W-1]^d[DATA_W-2]}
  - walking-one: starts at 1; rotates left by 1
- Loopback check: expect FIFO, depth 4.
  - On m_dout_vld: update last_rx and pop the FIFO. If m_dout ≠ popped value, increment err_count.
  - m_dout_vld with the FIFO empty also increments err_count; nothing is popped.
  - A push and a pop in the same cycle are both performed.
  - SEND holds m_din_vld low while the FIFO is full.

## Timing
- Reset values: m_din_vld=0, m_din_last=0, m_din=0, m_addr=0, busy=0, frame_count=0, err_count=0, last_rx=0. FSM returns to IDLE; FIFO, stop_pending and debounce state are cleared; the debounced button reads released.
- Reset mid-burst: abort immediately and emit no further frames. Both blocks share rst, so there is no in-flight SPI_MASTER handshake to finish.
- Press to first m_din_vld: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycle.
- All outputs are registered.
- m_din and m_din_last stay stable while m_din_vld=1 and m_ready=0.
- After an acceptance, the next frame is presented on the following cycle. With m_ready held high, the block sustains one frame per cycle.
- The last accepted frame of a burst is followed by m_din_vld=0 for at least DRAIN + GAP_CYCLES cycles.
- Input sampling: mode and pattern are sampled only on the IDLE→SEND transition. continuous is sampled at the end of GAP.

## Test plan
- DEBOUNCE_CYCLES=4, BURST_LEN=4, mode=00, pattern=0xFE, continuous=0, m_ready=1, m_dout looped to m_din one cycle after acceptance → m_din 0xFE,0xFF,0x00,0x01; m_din_last only on 0x01; frame_count=4; err_count=0; busy drops after GAP.
- 3-cycle glitch low on start_n, then 10 cycles stable low → no frames from the glitch; exactly one burst from the long press.
- mode=10, pattern=0x40, BURST_LEN=3 → 0x40, 0x81, 0x03. mode=11 → 0x01, 0x02, 0x04.
- continuous=1, SLAVE_COUNT=3 → m_addr 0,1,2,0 on successive bursts; a press during burst 4 → burst 4 completes with BURST_LEN frames, then IDLE.
- m_ready toggling 1/0 every cycle → m_din held stable while not ready; no dropped or duplicated frames. Corrupt the 2nd returned frame → err_count=1, last_rx = corrupted value. m_dout_vld pulse while IDLE → err_count increments.
- Assert rst during the 3rd frame of SEND → next cycle all outputs at reset values; a new press starts from pattern with k=0.
